// File: rtl/credit_ctrl_pkg.sv
// Shared dispenser-wide definitions: controller states, coin codes,
// selection tier field and the CIN thermometer codes.
package credit_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_REQ     = 3'd2,
    ST_DISP    = 3'd3,
    ST_REFUND  = 3'd4
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_FIVE = 2'b10;
  localparam logic [1:0] COIN_TEN  = 2'b11;

  localparam int SA_TIER_MSB = 3;
  localparam int SA_TIER_LSB = 2;

  localparam logic [1:0] TIER_NONE = 2'b00;
  localparam logic [1:0] TIER_LO   = 2'b01;
  localparam logic [1:0] TIER_MID  = 2'b10;
  localparam logic [1:0] TIER_HI   = 2'b11;

  localparam logic [2:0] CIN_NONE = 3'b000;
  localparam logic [2:0] CIN_LO   = 3'b001;
  localparam logic [2:0] CIN_MID  = 3'b011;
  localparam logic [2:0] CIN_HI   = 3'b111;

  function automatic logic [3:0] coinValue(input logic [1:0] coin);
    logic [3:0] value;
    value = 4'd0;
    case (coin)
      COIN_ONE:  value = 4'd1;
      COIN_FIVE: value = 4'd5;
      COIN_TEN:  value = 4'd10;
      default:   value = 4'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/credit_ctrl_coin_credit.sv
// Credit register: adds coins unless the sum would overflow, subtracts the
// price on a purchase and removes one unit per refund pulse.
module coin_credit
  import credit_ctrl_pkg::*;
#(
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                accept,
  input  logic                buy,
  input  logic [CREDIT_W-1:0] price,
  input  logic                dec,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject
);

  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] creditNext;
  logic                coinSeen;
  logic                addOk;

  // A coin landing in the purchase cycle is kept, so the price comes off the sum.
  always_comb begin
    coinSeen   = (coin != COIN_NONE);
    sum        = {1'b0, credit} + {{(CREDIT_W-3){1'b0}}, coinValue(coin)};
    addOk      = coinSeen && accept && !sum[CREDIT_W];
    reject     = coinSeen && !addOk;
    creditNext = addOk ? sum[CREDIT_W-1:0] : credit;
    if (buy) begin
      creditNext = creditNext - price;
    end
    if (dec) begin
      creditNext = creditNext - CREDIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit <= '0;
    end else begin
      credit <= creditNext;
    end
  end

endmodule

// File: rtl/credit_ctrl.sv
// Payment/selection front end: collects credit, requests a dispense when the
// selection is paid for, then hands back leftover credit one unit at a time.
module credit_ctrl
  import credit_ctrl_pkg::*;
#(
  parameter int PRICE_LO  = 5,
  parameter int PRICE_MID = 10,
  parameter int PRICE_HI  = 15,
  parameter int CREDIT_W  = 6,
  parameter int TIMEOUT   = 1000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          COIN,
  input  logic [3:0]          KEY,
  input  logic                KEY_V,
  input  logic                CANCEL,
  input  logic                DBUSY,
  output logic                E,
  output logic [3:0]          SA,
  output logic [2:0]          CIN,
  output logic [CREDIT_W-1:0] CREDIT,
  output logic                CHG,
  output logic                REJ,
  output logic                BUSY
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t              state;
  state_t              stateNext;
  logic [3:0]          saNext;
  logic                chgNext;
  logic [TW-1:0]       timer;
  logic [TW-1:0]       timerNext;
  logic                accept;
  logic                buy;
  logic                dec;
  logic                reject;
  logic                activity;
  logic                saValid;
  logic [CREDIT_W-1:0] price;

  always_comb begin
    price   = '0;
    saValid = 1'b0;
    case (SA[SA_TIER_MSB:SA_TIER_LSB])
      TIER_LO:  begin price = CREDIT_W'(PRICE_LO);  saValid = 1'b1; end
      TIER_MID: begin price = CREDIT_W'(PRICE_MID); saValid = 1'b1; end
      TIER_HI:  begin price = CREDIT_W'(PRICE_HI);  saValid = 1'b1; end
      default:  begin price = '0;                   saValid = 1'b0; end
    endcase
  end

  always_comb begin
    CIN = CIN_NONE;
    if (CREDIT >= CREDIT_W'(PRICE_HI)) begin
      CIN = CIN_HI;
    end else if (CREDIT >= CREDIT_W'(PRICE_MID)) begin
      CIN = CIN_MID;
    end else if (CREDIT >= CREDIT_W'(PRICE_LO)) begin
      CIN = CIN_LO;
    end
  end

  assign E    = (state == ST_REQ);
  assign BUSY = (state != ST_IDLE) && (state != ST_COLLECT);

  coin_credit #(.CREDIT_W(CREDIT_W)) u_credit (
    .clk    (CLK),
    .rst_n  (RESET),
    .coin   (COIN),
    .accept (accept),
    .buy    (buy),
    .price  (price),
    .dec    (dec),
    .credit (CREDIT),
    .reject (reject)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
      SA    <= '0;
      CHG   <= 1'b0;
      REJ   <= 1'b0;
      timer <= '0;
    end else begin
      state <= stateNext;
      SA    <= saNext;
      CHG   <= chgNext;
      REJ   <= reject;
      timer <= timerNext;
    end
  end

  // Cancel/timeout outrank a purchase; a new KEY never overwrites the paid selection.
  always_comb begin
    stateNext = state;
    saNext    = SA;
    chgNext   = 1'b0;
    timerNext = '0;
    accept    = 1'b0;
    buy       = 1'b0;
    dec       = 1'b0;
    activity  = (COIN != COIN_NONE) || KEY_V;
    case (state)
      ST_IDLE: begin
        accept = 1'b1;
        if (KEY_V) begin
          saNext = KEY;
        end
        if (COIN != COIN_NONE) begin
          stateNext = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        accept    = 1'b1;
        timerNext = activity ? '0 : timer + TW'(1);
        if (CANCEL || (!activity && timer == TW'(TIMEOUT - 1))) begin
          stateNext = ST_REFUND;
          timerNext = '0;
        end else if (saValid && CREDIT >= price) begin
          buy       = 1'b1;
          stateNext = ST_REQ;
          timerNext = '0;
        end
        if (KEY_V && !buy) begin
          saNext = KEY;
        end
      end
      ST_REQ: begin
        if (DBUSY) begin
          stateNext = ST_DISP;
        end
      end
      ST_DISP: begin
        if (!DBUSY) begin
          if (CREDIT != '0) begin
            stateNext = ST_REFUND;
          end else begin
            stateNext = ST_IDLE;
            saNext    = '0;
          end
        end
      end
      ST_REFUND: begin
        // Pulse on every other cycle; the unit leaves CREDIT as CHG rises.
        if (!CHG && CREDIT != '0) begin
          chgNext = 1'b1;
          dec     = 1'b1;
        end
        if (CREDIT == '0) begin
          stateNext = ST_IDLE;
          saNext    = '0;
        end
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_credit_ctrl.sv
// Randomised scoreboard bench for credit_ctrl: a behavioural model predicts
// every cycle's outputs, a monitor pops and compares them on the falling edge.
module tb_credit_ctrl;

  localparam int TIMEOUT = 24;
  localparam int MAXC    = 63;
  localparam int P_IDLE = 0, P_COLLECT = 1, P_REQ = 2, P_DISP = 3, P_REFUND = 4;

  typedef struct {
    logic [5:0] credit;
    logic [3:0] sa;
    logic       e;
    logic       chg;
    logic       rej;
    logic       busy;
    logic [2:0] cin;
  } snap_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] COIN;
  logic [3:0] KEY;
  logic       KEY_V;
  logic       CANCEL;
  logic       DBUSY;
  logic       E;
  logic [3:0] SA;
  logic [2:0] CIN;
  logic [5:0] CREDIT;
  logic       CHG;
  logic       REJ;
  logic       BUSY;

  snap_t      expQ[$];
  snap_t      monSnap;
  int         checks = 0;
  int         fails  = 0;

  int         mPhase;
  int         mCredit;
  logic [3:0] mSa;
  int         mIdle;
  int         mRefN;
  int         mRefK;
  logic       mChg;
  logic       mRej;
  logic       dbusyDrv;
  logic       holdBusy;

  credit_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .COIN(COIN), .KEY(KEY), .KEY_V(KEY_V),
    .CANCEL(CANCEL), .DBUSY(DBUSY), .E(E), .SA(SA), .CIN(CIN),
    .CREDIT(CREDIT), .CHG(CHG), .REJ(REJ), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int priceOf(input logic [3:0] sa);
    case (sa[3:2])
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 15;
      default: return 0;
    endcase
  endfunction

  function automatic int coinVal(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 5;
      2'b11:   return 10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] cinOf(input int cr);
    if (cr >= 15) return 3'b111;
    if (cr >= 10) return 3'b011;
    if (cr >= 5)  return 3'b001;
    return 3'b000;
  endfunction

  task automatic modelReset();
    mPhase = P_IDLE; mCredit = 0; mSa = 4'h0; mIdle = 0;
    mRefN = 0; mRefK = 0; mChg = 1'b0; mRej = 1'b0;
  endtask

  task automatic pushExpected();
    snap_t s;
    s.credit = 6'(mCredit);
    s.sa     = mSa;
    s.e      = (mPhase == P_REQ);
    s.busy   = (mPhase >= P_REQ);
    s.chg    = mChg;
    s.rej    = mRej;
    s.cin    = cinOf(mCredit);
    expQ.push_back(s);
  endtask

  // Refund is modelled as 2N cycles where odd cycles pay out one unit.
  task automatic modelStep(input logic [1:0] c, input logic kv, input logic [3:0] k,
                           input logic cn, input logic db);
    int  v;
    int  nc;
    bit  act;
    v    = coinVal(c);
    mRej = 1'b0;
    mChg = 1'b0;
    case (mPhase)
      P_IDLE: begin
        if (kv) mSa = k;
        if (c != 2'b00) begin
          mCredit += v;
          mPhase = P_COLLECT;
          mIdle  = 0;
        end
      end
      P_COLLECT: begin
        act = (c != 2'b00) || kv;
        nc  = mCredit;
        if (c != 2'b00) begin
          if (mCredit + v > MAXC) mRej = 1'b1;
          else nc = mCredit + v;
        end
        if (cn || (!act && mIdle == TIMEOUT - 1)) begin
          mPhase = P_REFUND; mRefN = nc; mRefK = 0; mIdle = 0;
        end else if (priceOf(mSa) > 0 && mCredit >= priceOf(mSa)) begin
          nc -= priceOf(mSa);
          mPhase = P_REQ; mIdle = 0;
        end else begin
          mIdle = act ? 0 : mIdle + 1;
        end
        if (kv && mPhase != P_REQ) mSa = k;
        mCredit = nc;
      end
      P_REQ: begin
        mRej = (c != 2'b00);
        if (db) mPhase = P_DISP;
      end
      P_DISP: begin
        mRej = (c != 2'b00);
        if (!db) begin
          if (mCredit > 0) begin
            mPhase = P_REFUND; mRefN = mCredit; mRefK = 0;
          end else begin
            mPhase = P_IDLE; mSa = 4'h0;
          end
        end
      end
      default: begin
        mRej = (c != 2'b00);
        if (mRefK >= 2 * mRefN - 1) begin
          mPhase = P_IDLE; mSa = 4'h0; mCredit = 0;
        end else begin
          mRefK++;
          mCredit = mRefN - (mRefK + 1) / 2;
          mChg    = (mRefK % 2 == 1);
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic kv, input logic [3:0] k, input logic cn);
    @(posedge CLK);
    #1;
    pushExpected();
    if (mPhase == P_REQ) begin
      if (holdBusy || $urandom_range(0, 2) == 0) dbusyDrv = 1'b1;
    end else if (mPhase == P_DISP) begin
      if (!holdBusy && $urandom_range(0, 3) == 0) dbusyDrv = 1'b0;
    end else begin
      dbusyDrv = 1'b0;
    end
    COIN = c; KEY_V = kv; KEY = k; CANCEL = cn; DBUSY = dbusyDrv;
    modelStep(c, kv, k, cn, dbusyDrv);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (mPhase != P_IDLE && n < budget) begin
      idleCycles(1);
      n++;
    end
    checkOutput("return to idle", 32'(mPhase), P_IDLE);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (expQ.size() > 0) begin
        monSnap = expQ.pop_front();
        checkOutput("CREDIT", 32'(CREDIT), 32'(monSnap.credit));
        checkOutput("SA",     32'(SA),     32'(monSnap.sa));
        checkOutput("E",      32'(E),      32'(monSnap.e));
        checkOutput("CHG",    32'(CHG),    32'(monSnap.chg));
        checkOutput("REJ",    32'(REJ),    32'(monSnap.rej));
        checkOutput("BUSY",   32'(BUSY),   32'(monSnap.busy));
        checkOutput("CIN",    32'(CIN),    32'(monSnap.cin));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " CREDIT"}, 32'(CREDIT), 0);
    checkOutput({tag, " SA"},     32'(SA),     0);
    checkOutput({tag, " E"},      32'(E),      0);
    checkOutput({tag, " CHG"},    32'(CHG),    0);
    checkOutput({tag, " REJ"},    32'(REJ),    0);
    checkOutput({tag, " BUSY"},   32'(BUSY),   0);
    checkOutput({tag, " CIN"},    32'(CIN),    0);
  endtask

  initial begin
    int n;
    logic [1:0] c;
    RESET = 1'b0; COIN = 2'b00; KEY = 4'h0; KEY_V = 1'b0; CANCEL = 1'b0; DBUSY = 1'b0;
    dbusyDrv = 1'b0; holdBusy = 1'b0;
    modelReset();
    #12;
    checkResetOutputs("reset");
    @(posedge CLK); #1 RESET = 1'b1;

    $display("[TB] basic purchase with change");
    applyStimulus(2'b10, 1'b0, 4'h0, 1'b0);
    applyStimulus(2'b01, 1'b1, 4'b0100, 1'b0);
    waitIdle(60);

    $display("[TB] exact payment at top tier");
    applyStimulus(2'b00, 1'b1, 4'b1100, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b10, 1'b0, 4'h0, 1'b0);
    waitIdle(60);

    $display("[TB] cancel with credit 7");
    applyStimulus(2'b10, 1'b0, 4'h0, 1'b0);
    applyStimulus(2'b01, 1'b0, 4'h0, 1'b0);
    applyStimulus(2'b01, 1'b0, 4'h0, 1'b0);
    applyStimulus(2'b00, 1'b0, 4'h0, 1'b1);
    waitIdle(40);

    $display("[TB] inactivity timeout with credit 3");
    for (int i = 0; i < 3; i++) applyStimulus(2'b01, 1'b0, 4'h0, 1'b0);
    waitIdle(TIMEOUT + 20);

    $display("[TB] overflow reject at credit 60");
    for (int i = 0; i < 6; i++) applyStimulus(2'b11, 1'b0, 4'h0, 1'b0);
    applyStimulus(2'b11, 1'b0, 4'h0, 1'b0);
    applyStimulus(2'b00, 1'b0, 4'h0, 1'b1);
    waitIdle(200);

    $display("[TB] coins during request and dispense");
    holdBusy = 1'b1;
    applyStimulus(2'b11, 1'b1, 4'b0100, 1'b0);
    applyStimulus(2'b00, 1'b0, 4'h0, 1'b0);
    applyStimulus(2'b01, 1'b0, 4'h0, 1'b1);
    applyStimulus(2'b10, 1'b0, 4'h0, 1'b0);
    holdBusy = 1'b0;
    waitIdle(60);

    $display("[TB] reset during dispense with credit 4");
    holdBusy = 1'b1;
    applyStimulus(2'b10, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(2'b01, 1'b0, 4'h0, 1'b0);
    applyStimulus(2'b00, 1'b1, 4'b0100, 1'b0);
    n = 0;
    while (mPhase != P_DISP && n < 20) begin
      idleCycles(1);
      n++;
    end
    checkOutput("reach dispense", 32'(mPhase), P_DISP);
    checkOutput("credit before reset", 32'(mCredit), 4);
    @(posedge CLK);
    #1;
    checkOutput("BUSY before reset", 32'(BUSY), 1);
    #1 RESET = 1'b0;
    #1;
    checkResetOutputs("async reset");
    holdBusy = 1'b0; dbusyDrv = 1'b0;
    COIN = 2'b00; KEY_V = 1'b0; KEY = 4'h0; CANCEL = 1'b0; DBUSY = 1'b0;
    modelReset();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    idleCycles(10);

    $display("[TB] randomised traffic");
    for (int i = 0; i < 2500; i++) begin
      if (i % 500 == 250) idleCycles(TIMEOUT + 10);
      c = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(c, ($urandom_range(0, 11) == 0), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 59) == 0));
    end
    waitIdle(300);

    @(negedge CLK);
    #1;
    checkOutput("queue drained", 32'(expQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
